// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoding constants: format codes, opcodes, immediate limits.
// Also used by the matching decoder blocks.
package instr_encoder_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned FMT_W = 3;
  localparam int unsigned OP_W  = 7;
  localparam int unsigned REG_W = 5;
  localparam int unsigned F3_W  = 3;

  typedef enum logic [FMT_W-1:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OP_W-1:0] OP_REG    = 7'b0110011;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -1048576;
  localparam int IMM21_MAX = 1048574;

  // One captured output beat: encoded word and its instruction address.
  typedef struct packed {
    logic [XLEN-1:0] word;
    logic [XLEN-1:0] addr;
  } out_beat_t;

  function automatic logic in_range(input logic [XLEN-1:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packing and immediate legality check.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [FMT_W-1:0] fmt,
  input  logic [OP_W-1:0]  op,
  input  logic [F3_W-1:0]  funct3,
  input  logic             funct7b5,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  word,
  output logic             legal
);

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (fmt)
      FMT_R: begin
        word  = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, op};
        legal = 1'b1;
      end
      FMT_I: begin
        word  = {imm[11:0], rs1, funct3, rd, op};
        legal = in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_S: begin
        word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
        legal = in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_B: begin
        word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
        legal = !imm[0] && in_range(imm, IMM13_MIN, IMM13_MAX);
      end
      FMT_U: begin
        word  = {imm[31:12], rd, op};
        legal = (imm[11:0] == 12'd0);
      end
      FMT_J: begin
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        legal = !imm[0] && in_range(imm, IMM21_MIN, IMM21_MAX);
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: one-entry output register, address counter
// and sticky error flag around the combinational packer.
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FMT_W-1:0] fmt,
  input  logic [OP_W-1:0]  op,
  input  logic [F3_W-1:0]  funct3,
  input  logic             funct7b5,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [XLEN-1:0]  imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_word,
  output logic [XLEN-1:0]  out_addr,
  input  logic             addr_load,
  input  logic [XLEN-1:0]  addr_base,
  output logic             err,
  input  logic             err_clr
);

  logic [XLEN-1:0] w_word;
  logic            w_legal;
  logic            w_accept;
  logic            w_out_hs;
  logic [XLEN-1:0] w_cnt_next;

  logic            r_out_valid;
  out_beat_t       r_out;
  logic [XLEN-1:0] r_cnt;
  logic            r_err;

  instr_pack u_pack (
    .fmt      (fmt),
    .op       (op),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .imm      (imm),
    .word     (w_word),
    .legal    (w_legal)
  );

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_out_hs = r_out_valid && out_ready;

  // A word captured alongside a handshake belongs to the next slot (+4).
  assign w_cnt_next = addr_load ? addr_base :
                      w_out_hs  ? r_cnt + XLEN'(4) : r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_accept && w_legal) begin
        r_out_valid <= 1'b1;
        r_out.word  <= w_word;
        r_out.addr  <= w_cnt_next;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept && !w_legal) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_word  = r_out.word;
  assign out_addr  = r_out.addr;
  assign err       = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed literal cases plus
// randomized traffic compared every cycle against a behavioural model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [31:0] out_addr;
  logic        addr_load;
  logic [31:0] addr_base;
  logic        err;
  logic        err_clr;

  int n_checks = 0;
  int n_errors = 0;

  instr_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_addr(out_addr), .addr_load(addr_load), .addr_base(addr_base),
    .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference encoder built from shifts/masks and integer range tests.
  function automatic bit [31:0] enc(input int f, input bit [31:0] o, input bit [31:0] f3,
                                    input bit [31:0] f7, input bit [31:0] d, input bit [31:0] s1,
                                    input bit [31:0] s2, input bit [31:0] im, output bit ok);
    int s;
    bit [31:0] base;
    s = $signed(im);
    base = o | (f3 << 12) | (s1 << 15);
    case (f)
      0: begin ok = 1; return base | (d << 7) | (s2 << 20) | (f7 << 30); end
      1: begin ok = (s >= -2048 && s <= 2047); return base | (d << 7) | ((im & 32'hFFF) << 20); end
      2: begin
        ok = (s >= -2048 && s <= 2047);
        return base | (s2 << 20) | ((im & 32'h1F) << 7) | (((im >> 5) & 32'h7F) << 25);
      end
      3: begin
        ok = ((im & 1) == 0) && (s >= -4096 && s <= 4094);
        return base | (s2 << 20) | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 1) << 7)
                    | (((im >> 5) & 32'h3F) << 25) | (((im >> 12) & 1) << 31);
      end
      4: begin ok = ((im & 32'hFFF) == 0); return o | (d << 7) | (im & 32'hFFFFF000); end
      5: begin
        ok = ((im & 1) == 0) && (s >= -1048576 && s <= 1048574);
        return o | (d << 7) | (((im >> 12) & 32'hFF) << 12) | (((im >> 11) & 1) << 20)
                 | (((im >> 1) & 32'h3FF) << 21) | (((im >> 20) & 1) << 31);
      end
      default: begin ok = 0; return 32'd0; end
    endcase
  endfunction

  // Behavioural model of the visible state.
  logic        m_valid;
  logic [31:0] m_word, m_addr, m_cnt;
  logic        m_err;

  always @(posedge clk or posedge reset) begin
    bit acc, hs, ok;
    bit [31:0] w, nxt;
    if (reset) begin
      m_valid <= 0; m_word <= 0; m_addr <= 0; m_cnt <= 0; m_err <= 0;
    end else begin
      acc = in_valid && (!m_valid || out_ready);
      hs  = m_valid && out_ready;
      w = enc(int'(fmt), 32'(op), 32'(funct3), 32'(funct7b5), 32'(rd), 32'(rs1), 32'(rs2), imm, ok);
      if (addr_load) nxt = addr_base;
      else if (hs)   nxt = m_cnt + 4;
      else           nxt = m_cnt;
      m_cnt <= nxt;
      if (acc && ok) begin
        m_valid <= 1; m_word <= w; m_addr <= nxt;
      end else if (hs) begin
        m_valid <= 0;
      end
      if (acc && !ok)   m_err <= 1;
      else if (err_clr) m_err <= 0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cmp_in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    chk("cmp_out_valid", 32'(out_valid), 32'(m_valid));
    chk("cmp_err", 32'(err), 32'(m_err));
    if (m_valid) begin
      chk("cmp_out_word", out_word, m_word);
      chk("cmp_out_addr", out_addr, m_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; addr_load = 0; err_clr = 0;
  endtask

  task automatic set_instr(input int f, input int o, input int f3, input int f7,
                           input int d, input int s1, input int s2, input int im);
    in_valid = 1;
    fmt = 3'(f); op = 7'(o); funct3 = 3'(f3); funct7b5 = 1'(f7);
    rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); imm = 32'(im);
  endtask

  int bnd [17] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                   -1048577, -1048576, 1048574, 1048575, 1048576, 0, 1, -1};

  initial begin
    bit ok;
    reset = 1; out_ready = 1; addr_base = 0;
    idle();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_word", out_word, 32'd0);
    chk("reset_out_addr", out_addr, 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    reset = 0;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // Pin the reference encoder to hand-computed words.
    chk("model_r_add", enc(0, 32'h33, 0, 0, 3, 1, 2, 0, ok), 32'h002081B3);
    chk("model_i_addi", enc(1, 32'h13, 0, 0, 5, 0, 0, 32'hFFFFFFFF, ok), 32'hFFF00293);
    chk("model_b_beq", enc(3, 32'h63, 0, 0, 0, 1, 2, 8, ok), 32'h00208463);
    chk("model_j_jal", enc(5, 32'h6F, 0, 0, 1, 0, 0, 2048, ok), 32'h001000EF);
    chk("model_s_sw", enc(2, 32'h23, 2, 0, 0, 2, 5, 32'hFFFFFFFC, ok), 32'hFE512E23);
    void'(enc(1, 32'h13, 0, 0, 5, 0, 0, 2048, ok));
    chk("model_i_range", 32'(ok), 32'd0);

    set_instr(0, 'h33, 0, 0, 3, 1, 2, 0); tick();
    chk("r_add_valid", 32'(out_valid), 32'd1);
    chk("r_add_word", out_word, 32'h002081B3);
    chk("r_add_addr", out_addr, 32'h0);
    set_instr(1, 'h13, 0, 0, 5, 0, 0, -1); tick();
    chk("addi_word", out_word, 32'hFFF00293);
    chk("addi_addr", out_addr, 32'h4);
    set_instr(3, 'h63, 0, 0, 0, 1, 2, 8); tick();
    chk("beq_word", out_word, 32'h00208463);
    chk("beq_addr", out_addr, 32'h8);
    set_instr(5, 'h6F, 0, 0, 1, 0, 0, 2048); tick();
    chk("jal_word", out_word, 32'h001000EF);
    chk("jal_addr", out_addr, 32'hC);

    // Out-of-range immediate: consumed silently, sticky error raised.
    set_instr(1, 'h13, 0, 0, 5, 0, 0, 2048); tick();
    chk("range_no_valid", 32'(out_valid), 32'd0);
    chk("range_err_set", 32'(err), 32'd1);
    idle(); tick();
    chk("range_err_sticky", 32'(err), 32'd1);
    err_clr = 1; tick();
    chk("range_err_clr", 32'(err), 32'd0);
    err_clr = 0;
    set_instr(1, 'h13, 0, 0, 5, 0, 0, -1); tick();
    chk("range_cnt_kept", out_addr, 32'h10);
    idle(); tick();

    // Backpressure: hold the word, then release into a back-to-back pair.
    out_ready = 0;
    set_instr(2, 'h23, 2, 0, 0, 2, 5, -4); tick();
    chk("bp_w1_word", out_word, 32'hFE512E23);
    set_instr(4, 'h37, 0, 0, 10, 0, 0, 32'h12345000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_word", out_word, 32'hFE512E23);
      chk("bp_hold_addr", out_addr, 32'h14);
    end
    out_ready = 1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp_w2_word", out_word, 32'h12345537);
    chk("bp_w2_addr", out_addr, 32'h18);
    idle(); tick();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Address reload, then reset while a word is pending.
    addr_load = 1; addr_base = 32'h00001000; tick();
    addr_load = 0;
    set_instr(0, 'h33, 0, 0, 3, 1, 2, 0); tick();
    chk("load_addr", out_addr, 32'h00001000);
    out_ready = 0; idle(); tick();
    chk("load_pending", 32'(out_valid), 32'd1);
    reset = 1;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_word", out_word, 32'd0);
    tick();
    reset = 0; out_ready = 1;
    tick();

    // Randomized traffic checked by the per-cycle compare process.
    for (int n = 0; n < 3000; n++) begin
      int mode;
      in_valid  = ($urandom_range(0, 9) < 7);
      fmt       = 3'($urandom_range(0, 7));
      op        = 7'($urandom);
      funct3    = 3'($urandom);
      funct7b5  = 1'($urandom);
      rd        = 5'($urandom);
      rs1       = 5'($urandom);
      rs2       = 5'($urandom);
      mode      = $urandom_range(0, 3);
      case (mode)
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: imm = 32'(bnd[$urandom_range(0, 16)]);
        default: imm = $urandom & 32'hFFFFF000;
      endcase
      out_ready = ($urandom_range(0, 9) < 7);
      err_clr   = ($urandom_range(0, 9) == 0);
      addr_load = !m_valid && ($urandom_range(0, 29) == 0);
      addr_base = $urandom & 32'hFFFFFFFC;
      if ($urandom_range(0, 99) == 0) addr_base = 32'hFFFFFFF8;
      tick();
    end
    idle(); out_ready = 1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising edge; reset  in  1  asynchronous, active-high.
REQ-002 SHALL have: in_valid in 1 field set present; in_ready out 1 encoder can accept.
REQ-003 SHALL have: fmt in 3 (0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6-7 illegal); op in 7; funct3 in 3; funct7b5 in 1.
REQ-004 SHALL have: rd in 5; rs1 in 5; rs2 in 5; imm in 32, a two's-complement byte offset or value.
REQ-005 SHALL have: out_valid out 1; out_ready in 1; out_word out 32 encoded RV32I instruction; out_addr out 32 instruction-memory byte address.
REQ-006 SHALL have: addr_load in 1 load base; addr_base in 32 base value; err out 1 sticky error; err_clr in 1.

Function
REQ-007 SHALL encode R as {0,funct7b5,00000, rs2, rs1, funct3, rd, op}.
REQ-008 SHALL encode I as {imm[11:0], rs1, funct3, rd, op}; legal iff imm in [-2048, 2047].
REQ-009 SHALL encode S as {imm[11:5], rs2, rs1, funct3, imm[4:0], op}; legal iff imm in [-2048, 2047].
REQ-010 SHALL encode B as {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}; legal iff imm[0]=0 and imm in [-4096, 4094].
REQ-011 SHALL encode U as {imm[31:12], rd, op}; legal iff imm[11:0]=0.
REQ-012 SHALL encode J as {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}; legal iff imm[0]=0 and imm in [-1048576, 1048574].
REQ-013 SHALL treat fmt 6-7 as illegal; fields unused by a format are ignored.
REQ-014 SHALL accept input on the cycle where in_valid and in_ready are both high.
REQ-015 SHALL drive in_ready = !out_valid | out_ready (one-entry output register, no combinational path from in_valid to out_valid).
REQ-016 SHALL present a legal accepted word on out_word with out_valid high exactly one cycle after acceptance.
REQ-017 SHALL hold out_word, out_addr and out_valid stable while out_valid=1 and out_ready=0.
REQ-018 SHALL clear out_valid after an output handshake unless a new legal word is accepted in the same cycle, which then replaces it back-to-back.
REQ-019 SHALL consume an illegal input without producing output, leaving out_addr unchanged and setting err the next cycle.
REQ-020 SHALL increment the address counter by 4 on each output handshake, wrapping modulo 2^32; out_addr equals counter value when the word was captured.
REQ-021 SHALL, on addr_load, set the counter to addr_base; addr_load takes priority over a simultaneous increment.
REQ-022 SHALL not assert addr_load while out_valid=1 (caller rule); behaviour then is that the pending word keeps its captured address.
REQ-023 SHALL clear err on err_clr; a new error in the same cycle wins (err stays 1).

Reset
REQ-024 SHALL on reset (asynchronous, active-high) force out_valid=0, out_word=0, out_addr=0, address counter=0, err=0; in_ready=1 while reset is deasserted and output empty.
REQ-025 SHALL discard any pending output word when reset is asserted mid-transfer; no partial handshake survives.

Structure
REQ-026 SHALL place fmt codes (FMT_R..FMT_J), RV32I opcode constants and immediate range limits in a shared package used also by the decoders.
REQ-027 SHALL isolate the combinational field packing and legality check in one sub-module, instr_pack (inputs fmt/op/funct3/funct7b5/rd/rs1/rs2/imm; outputs word, legal).
REQ-028 SHALL keep all state (output register, address counter, err) in instr_encoder.

Verification
REQ-029 SHALL test R add: fmt=0 op=0x33 f3=0 f7b5=0 rd=3 rs1=1 rs2=2 -> out_word=0x002081B3, out_addr=0x00000000.
REQ-030 SHALL test I addi: fmt=1 op=0x13 rd=5 rs1=0 imm=-1 -> 0xFFF00293 at out_addr=0x00000004.
REQ-031 SHALL test B beq: fmt=3 op=0x63 rs1=1 rs2=2 imm=8 -> 0x00208463; J jal fmt=5 op=0x6F rd=1 imm=2048 -> 0x001000EF.
REQ-032 SHALL test range error: fmt=1 imm=2048 -> no out_valid, err=1 next cycle, counter unchanged; err_clr -> err=0.
REQ-033 SHALL test backpressure: out_ready=0 for 3 cycles -> in_ready=0, out_word/out_addr stable; release -> back-to-back words at +4 addresses.
REQ-034 SHALL test addr_load=1 addr_base=0x00001000 then one word -> out_addr=0x00001000; reset asserted with out_valid=1 -> out_valid=0 immediately.
